// File: rtl/sysbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_pkg
// Description : Shared types, tag-field constants and the MMIO window helper
//               for the Sysbus arbiter and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package sysbus_pkg;

  // Tag rw field
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Tag type field
  localparam logic [3:0] MEMORY = 4'b0001;
  localparam logic [3:0] MMIO   = 4'b0011;

  // Default MMIO window, both bounds exclusive
  localparam logic [63:0] MMIO_LO_DEF = 64'd655360;   // 640 KiB
  localparam logic [63:0] MMIO_HI_DEF = 64'd1048576;  // 1 MiB

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

  // True when addr lies strictly inside (lo, hi)
  function automatic logic is_mmio(input logic [63:0] addr,
                                   input logic [63:0] lo = MMIO_LO_DEF,
                                   input logic [63:0] hi = MMIO_HI_DEF);
    return (addr > lo) && (addr < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sysbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_arbiter_if
// Description : Bundles the fetch port, the data port and the Sysbus master
//               port. "master" is the arbiter's view, "slave" the view of
//               everything around it (requesters and the bus).
// Revision    : 1.0 - initial release
// ============================================================================
interface sysbus_arbiter_if #(
  parameter int TAG_W = 13
);
  // Fetch port
  logic             if_req_valid;
  logic [63:0]      if_req_addr;
  logic             if_req_ready;
  logic             if_resp_valid;
  logic [63:0]      if_resp_data;
  // Data port
  logic             dm_req_valid;
  logic             dm_req_write;
  logic [63:0]      dm_req_addr;
  logic             dm_req_ready;
  logic [63:0]      dm_wdata;
  logic             dm_wdata_ready;
  logic             dm_resp_valid;
  logic [63:0]      dm_resp_data;
  // Sysbus
  logic             bus_reqcyc;
  logic [63:0]      bus_req;
  logic [TAG_W-1:0] bus_reqtag;
  logic             bus_reqack;
  logic             bus_respcyc;
  logic [63:0]      bus_resp;
  logic             bus_respack;

  modport master (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  dm_req_valid, dm_req_write, dm_req_addr, dm_wdata,
    output dm_req_ready, dm_wdata_ready, dm_resp_valid, dm_resp_data,
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp
  );

  modport slave (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output dm_req_valid, dm_req_write, dm_req_addr, dm_wdata,
    input  dm_req_ready, dm_wdata_ready, dm_resp_valid, dm_resp_data,
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp
  );

endinterface
`default_nettype wire

// File: rtl/sysbus_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin pick. The pick is combinational; the
//               last-grant history only moves when the owner finishes, so a
//               later store-buffer port can reuse the same block.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import sysbus_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [1:0] req_i,        // [0] = IF, [1] = DM
  input  wire logic       upd_en_i,     // transaction finished this cycle
  input  requester_t      upd_who_i,    // requester that just finished
  output logic            gnt_valid_o,
  output requester_t      gnt_who_o
);

  requester_t last_grant_q;

  // Pick the only requester, or on a tie the one not served last
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_who_o   = REQ_IF;
    if (req_i[0] && req_i[1]) begin
      gnt_who_o = (last_grant_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_i[1]) begin
      gnt_who_o = REQ_DM;
    end
  end

  // History starts at DM so fetch wins the first tie after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= REQ_DM;
    end else if (upd_en_i) begin
      last_grant_q <= upd_who_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_arbiter
// Description : Shares one Sysbus master port between instruction fetch and
//               the load/store unit. One line transaction in flight at a
//               time; address phase, then either BEATS write beats streamed
//               from the data unit or BEATS read beats routed to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int          BEATS           = 8,
  parameter int          TAG_W           = 13,
  parameter logic [63:0] MMIO_LO         = 64'(640 * 1024),
  parameter logic [63:0] MMIO_HI         = 64'(1024 * 1024),
  parameter bit          STRICT_PROTOCOL = 1'b1   // stop simulation on stray response beats
)(
  input  wire logic          clk,
  input  wire logic          reset,
  sysbus_arbiter_if.master   bus
);

  localparam int          CNT_W     = $clog2(BEATS) + 1;
  localparam logic [63:0] LINE_MASK = 64'(BEATS * 8 - 1);

  arb_state_t       state_q;
  requester_t       owner_q;
  logic             write_q;
  logic             reqcyc_q;
  logic [63:0]      req_q;
  logic [TAG_W-1:0] tag_q;
  logic             if_ready_q;
  logic             dm_ready_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic             gnt_valid;
  requester_t       gnt_who;
  logic [63:0]      req_addr_d;
  logic             write_d;
  logic [TAG_W-1:0] tag_d;
  logic             last_beat;
  logic             resp_fire;
  logic             wdata_fire;
  logic             arb_upd;
  requester_t       arb_upd_who;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       ({bus.dm_req_valid, bus.if_req_valid}),
    .upd_en_i    (arb_upd),
    .upd_who_i   (arb_upd_who),
    .gnt_valid_o (gnt_valid),
    .gnt_who_o   (gnt_who)
  );

  // Address, direction and tag of whichever requester the arbiter picks
  always_comb begin
    req_addr_d = (gnt_who == REQ_DM) ? bus.dm_req_addr : bus.if_req_addr;
    write_d    = (gnt_who == REQ_DM) ? bus.dm_req_write : READ;
    tag_d      = {write_d,
                  is_mmio(req_addr_d, MMIO_LO, MMIO_HI) ? MMIO : MEMORY,
                  {(TAG_W - 5){1'b0}}};
  end

  // Beat bookkeeping and the history update at the end of a transaction
  always_comb begin
    last_beat   = (beat_cnt_q == CNT_W'(BEATS - 1));
    resp_fire   = (state_q == RESP) && bus.bus_respcyc;
    wdata_fire  = (state_q == WDATA) && bus.bus_reqack;
    arb_upd     = (resp_fire || wdata_fire) && last_beat;
    arb_upd_who = (state_q == WDATA) ? REQ_DM : owner_q;
  end

  // Response beats are always acknowledged; stray ones are simply dropped
  assign bus.bus_respack    = bus.bus_respcyc;
  assign bus.bus_reqcyc     = reqcyc_q;
  assign bus.bus_req        = (state_q == WDATA) ? bus.dm_wdata : req_q;
  assign bus.bus_reqtag     = tag_q;
  assign bus.if_req_ready   = if_ready_q;
  assign bus.dm_req_ready   = dm_ready_q;
  assign bus.dm_wdata_ready = wdata_fire;
  assign bus.if_resp_valid  = resp_fire && (owner_q == REQ_IF);
  assign bus.dm_resp_valid  = resp_fire && (owner_q == REQ_DM);
  assign bus.if_resp_data   = (owner_q == REQ_IF) ? bus.bus_resp : 64'd0;
  assign bus.dm_resp_data   = (owner_q == REQ_DM) ? bus.bus_resp : 64'd0;

  // Transaction FSM: grant, address phase, then write stream or read return
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IF;
      write_q    <= READ;
      reqcyc_q   <= 1'b0;
      req_q      <= 64'd0;
      tag_q      <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q    <= gnt_who;
            write_q    <= write_d;
            req_q      <= req_addr_d & ~LINE_MASK;
            tag_q      <= tag_d;
            reqcyc_q   <= 1'b1;
            if_ready_q <= (gnt_who == REQ_IF);
            dm_ready_q <= (gnt_who == REQ_DM);
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.bus_reqack) begin
            beat_cnt_q <= '0;
            if (write_q) begin
              state_q <= WDATA;
            end else begin
              reqcyc_q <= 1'b0;
              state_q  <= RESP;
            end
          end
        end
        WDATA: begin
          if (bus.bus_reqack) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (last_beat) begin
              reqcyc_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        RESP: begin
          if (bus.bus_respcyc) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (STRICT_PROTOCOL) begin : g_resp_check
      // A response beat with no read in flight means the bus is broken
      always_ff @(posedge clk) begin
        if (!reset) begin
          assert (!(bus.bus_respcyc && (state_q != RESP)))
            else $fatal(1, "sysbus_arbiter: response beat outside RESP");
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysbus_arbiter
// Description : Self-checking bench for sysbus_arbiter with directed
//               scenarios and a randomized round-robin run against a
//               transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;

  localparam int BEATS = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   model_last;   // 1 = data unit was served last

  sysbus_arbiter_if #(.TAG_W(13)) sb ();

  sysbus_arbiter #(
    .BEATS           (BEATS),
    .TAG_W           (13),
    .MMIO_LO         (64'd655360),
    .MMIO_HI         (64'd1048576),
    .STRICT_PROTOCOL (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tag: rw*4096 + type*256, type 3 strictly inside the window
  function automatic logic [12:0] exp_tag(input bit wr, input logic [63:0] a);
    int unsigned ty;
    ty = (a > 64'd655360 && a < 64'd1048576) ? 3 : 1;
    return 13'(wr * 4096 + ty * 256);
  endfunction

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a - (a % 64);
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'd655360 + 64'($urandom_range(0, 4)) - 64'd2;
      2:       return 64'd1048576 + 64'($urandom_range(0, 4)) - 64'd2;
      default: return 64'($urandom_range(0, 2000000));
    endcase
  endfunction

  task automatic expect_grant(input bit dm, output int waited);
    logic [1:0] exp_rdy;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(sb.if_req_ready || sb.dm_req_ready) && waited < 20);
    exp_rdy = dm ? 2'b01 : 2'b10;
    n_tests++;
    if ({sb.if_req_ready, sb.dm_req_ready} !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant: {if_rdy,dm_rdy} got %b expected %b after %0d cycles",
               {sb.if_req_ready, sb.dm_req_ready}, exp_rdy, waited);
    end
  endtask

  task automatic addr_phase(input bit dm, input logic [63:0] er,
                            input logic [12:0] et, input int stall);
    logic [1:0] exp_rdy;
    for (int i = 0; i <= stall; i++) begin
      sb.bus_reqack = (i == stall);
      exp_rdy = (i == 0) ? (dm ? 2'b01 : 2'b10) : 2'b00;
      n_tests++;
      if ({sb.bus_reqcyc, sb.bus_req, sb.bus_reqtag, sb.if_req_ready, sb.dm_req_ready,
           sb.dm_wdata_ready} !== {1'b1, er, et, exp_rdy, 1'b0}) begin
        n_fail++;
        $display("FAIL addr_phase[%0d]: cyc=%b req=%h tag=%h rdy=%b%b wrdy=%b expected req=%h tag=%h",
                 i, sb.bus_reqcyc, sb.bus_req, sb.bus_reqtag, sb.if_req_ready,
                 sb.dm_req_ready, sb.dm_wdata_ready, er, et);
      end
      tick();
    end
    sb.bus_reqack = 1'b0;
  endtask

  task automatic write_phase(input logic [63:0] base, input bit rnd_ack);
    int got   = 0;
    int guard = 0;
    int rdy   = 0;
    bit ack;
    while (got < BEATS && guard < 200) begin
      guard++;
      ack = rnd_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
      sb.bus_reqack = ack;
      sb.dm_wdata   = base + 64'(got);
      #1;
      n_tests++;
      if ({sb.bus_reqcyc, sb.dm_wdata_ready, sb.bus_req, sb.dm_resp_valid, sb.if_resp_valid}
          !== {1'b1, ack, base + 64'(got), 2'b00}) begin
        n_fail++;
        $display("FAIL write_beat[%0d]: cyc=%b wrdy=%b req=%h expected wrdy=%b req=%h",
                 got, sb.bus_reqcyc, sb.dm_wdata_ready, sb.bus_req, ack, base + 64'(got));
      end
      if (sb.dm_wdata_ready) rdy++;
      tick();
      if (ack) got++;
    end
    sb.bus_reqack = 1'b0;
    n_tests++;
    if (sb.bus_reqcyc !== 1'b0 || rdy != BEATS || guard >= 200) begin
      n_fail++;
      $display("FAIL write_end: cyc=%b wdata_ready_cycles=%0d expected cyc=0 and %0d",
               sb.bus_reqcyc, rdy, BEATS);
    end
  endtask

  task automatic read_phase(input bit dm, input int nbeats, input bit pattern);
    int got   = 0;
    int guard = 0;
    logic [63:0] d;
    logic        cyc;
    logic        own_v, oth_v;
    logic [63:0] own_d;
    while (got < nbeats && guard < 200) begin
      guard++;
      cyc = ($urandom_range(0, 3) != 0);
      d   = pattern ? 64'(got + 1) * 64'h11 : {$urandom, $urandom};
      sb.bus_respcyc = cyc;
      sb.bus_resp    = d;
      #1;
      own_v = dm ? sb.dm_resp_valid : sb.if_resp_valid;
      oth_v = dm ? sb.if_resp_valid : sb.dm_resp_valid;
      own_d = dm ? sb.dm_resp_data : sb.if_resp_data;
      n_tests++;
      if ({own_v, oth_v, sb.bus_respack, sb.bus_reqcyc, sb.if_req_ready, sb.dm_req_ready}
          !== {cyc, 1'b0, cyc, 3'b000} || (cyc && own_d !== d)) begin
        n_fail++;
        $display("FAIL read_beat[%0d]: own_v=%b oth_v=%b ack=%b cyc=%b data=%h expected v=%b data=%h",
                 got, own_v, oth_v, sb.bus_respack, sb.bus_reqcyc, own_d, cyc, d);
      end
      tick();
      if (cyc) got++;
    end
    sb.bus_respcyc = 1'b0;
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL read_timeout: got %0d beats expected %0d", got, nbeats);
    end
  endtask

  task automatic do_txn(input bit dm, input bit wr, input logic [63:0] a,
                        input int stall, input bit pattern, input logic [63:0] wbase);
    int w;
    if (dm) begin
      sb.dm_req_valid = 1'b1;
      sb.dm_req_write = wr;
      sb.dm_req_addr  = a;
    end else begin
      sb.if_req_valid = 1'b1;
      sb.if_req_addr  = a;
    end
    expect_grant(dm, w);
    sb.if_req_valid = 1'b0;
    sb.dm_req_valid = 1'b0;
    addr_phase(dm, line_of(a), exp_tag(dm && wr, a), stall);
    if (dm && wr) write_phase(wbase, 1'b1);
    else          read_phase(dm, BEATS, pattern);
    model_last = dm;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.if_req_valid = 1'b0; sb.if_req_addr  = '0;
    sb.dm_req_valid = 1'b0; sb.dm_req_write = 1'b0; sb.dm_req_addr = '0;
    sb.dm_wdata     = '0;
    sb.bus_reqack   = 1'b0; sb.bus_respcyc  = 1'b0; sb.bus_resp    = '0;
    tick();
    tick();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({sb.bus_reqcyc, sb.bus_req, sb.bus_reqtag, sb.if_req_ready, sb.dm_req_ready,
         sb.if_resp_valid, sb.dm_resp_valid, sb.dm_wdata_ready, sb.bus_respack} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: cyc=%b req=%h tag=%h rdy=%b%b rv=%b%b wrdy=%b expected all 0",
               sb.bus_reqcyc, sb.bus_req, sb.bus_reqtag, sb.if_req_ready, sb.dm_req_ready,
               sb.if_resp_valid, sb.dm_resp_valid, sb.dm_wdata_ready);
    end
  endtask

  task automatic test_if_read();
    do_txn(1'b0, 1'b0, 64'h400123, 0, 1'b1, 64'd0);
    n_tests++;
    if (sb.bus_reqcyc !== 1'b0 || sb.if_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_idle: cyc=%b rdy=%b expected 0 0", sb.bus_reqcyc, sb.if_req_ready);
    end
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    sb.if_req_valid = 1'b1; sb.if_req_addr = 64'h1000;
    sb.dm_req_valid = 1'b1; sb.dm_req_write = 1'b0; sb.dm_req_addr = 64'h3008;
    expect_grant(1'b0, w);
    sb.if_req_valid = 1'b0;
    addr_phase(1'b0, 64'h1000, exp_tag(1'b0, 64'h1000), 1);
    read_phase(1'b0, BEATS, 1'b0);
    expect_grant(1'b1, w);
    n_tests++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL rr_gap: DM granted after %0d cycles expected 1", w);
    end
    sb.dm_req_valid = 1'b0;
    addr_phase(1'b1, 64'h3000, exp_tag(1'b0, 64'h3008), 0);
    read_phase(1'b1, BEATS, 1'b0);
    model_last = 1'b1;
  endtask

  task automatic test_write_stall();
    do_txn(1'b1, 1'b1, 64'h2000, 3, 1'b0, 64'hA0);
  endtask

  task automatic test_mmio();
    do_txn(1'b1, 1'b0, 64'hB8000, 0, 1'b0, 64'd0);   // inside window
    do_txn(1'b1, 1'b0, 64'h100000, 0, 1'b0, 64'd0);  // upper bound excluded
    do_txn(1'b1, 1'b0, 64'hA0000, 0, 1'b0, 64'd0);   // lower bound excluded
  endtask

  task automatic test_reset_mid();
    int w;
    sb.if_req_valid = 1'b1; sb.if_req_addr = 64'h8000;
    expect_grant(1'b0, w);
    sb.if_req_valid = 1'b0;
    addr_phase(1'b0, 64'h8000, exp_tag(1'b0, 64'h8000), 0);
    read_phase(1'b0, 4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last = 1'b1;
    sb.bus_respcyc = 1'b1;
    sb.bus_resp    = 64'hDEAD;
    #1;
    n_tests++;
    if ({sb.bus_reqcyc, sb.if_resp_valid, sb.dm_resp_valid, sb.bus_respack} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid: cyc=%b rv=%b%b ack=%b expected 0 00 1",
               sb.bus_reqcyc, sb.if_resp_valid, sb.dm_resp_valid, sb.bus_respack);
    end
    sb.bus_respcyc = 1'b0;
    tick();
    do_txn(1'b0, 1'b0, 64'h1234, 1, 1'b0, 64'd0);
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      sb.bus_respcyc = 1'b1;
      sb.bus_resp    = {$urandom, $urandom};
      #1;
      n_tests++;
      if ({sb.bus_respack, sb.if_resp_valid, sb.dm_resp_valid, sb.bus_reqcyc} !== 4'b1000) begin
        n_fail++;
        $display("FAIL spurious[%0d]: ack=%b rv=%b%b cyc=%b expected 1 00 0",
                 i, sb.bus_respack, sb.if_resp_valid, sb.dm_resp_valid, sb.bus_reqcyc);
      end
      tick();
    end
    sb.bus_respcyc = 1'b0;
    do_txn(1'b1, 1'b1, 64'h7777, 0, 1'b0, 64'h5000);
  endtask

  task automatic test_random();
    int w;
    bit both, win, wr;
    logic [63:0] a_if, a_dm, a;
    for (int k = 0; k < 16; k++) begin
      both = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      a_if = rand_addr();
      a_dm = rand_addr();
      if (both) begin
        win = !model_last;
        sb.if_req_valid = 1'b1; sb.if_req_addr = a_if;
        sb.dm_req_valid = 1'b1; sb.dm_req_write = wr; sb.dm_req_addr = a_dm;
      end else begin
        win = 1'($urandom_range(0, 1));
        if (win) begin
          sb.dm_req_valid = 1'b1; sb.dm_req_write = wr; sb.dm_req_addr = a_dm;
        end else begin
          sb.if_req_valid = 1'b1; sb.if_req_addr = a_if;
        end
      end
      expect_grant(win, w);
      n_tests++;
      if (w != 1) begin
        n_fail++;
        $display("FAIL rand_latency[%0d]: grant after %0d cycles expected 1", k, w);
      end
      sb.if_req_valid = 1'b0;
      sb.dm_req_valid = 1'b0;
      a = win ? a_dm : a_if;
      addr_phase(win, line_of(a), exp_tag(win && wr, a), $urandom_range(0, 3));
      if (win && wr) write_phase({$urandom, $urandom}, 1'b1);
      else           read_phase(win, BEATS, 1'b0);
      model_last = win;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_if_read();
    test_round_robin();
    test_write_stall();
    test_mmio();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
